branch_ctrl: RTL and testbench

ID-stage branch sequencer that schedules the branch comparator: detects RAW hazards on comparator operands, stalls IF/ID until operands are forwardable, selects operand forwarding, and drives PC select/flush from the comparator's taken flag and exceptions. Sits between the hazard/forwarding paths of EX, MEM and WB and the PC mux in IF. It also keeps saturating branch/taken performance counters.

---
 rtl/branch_ctrl_pkg.sv | 83 ++++++++
 rtl/branch_hazard_detect.sv | 68 ++++++
 rtl/branch_ctrl.sv | 136 +++++++++++++
 tb/tb_branch_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared decode constants, PC/forwarding select encodings and FSM state type
// for the ID-stage branch sequencer.
package branch_ctrl_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_TEQ     = 6'h34;

   localparam logic [4:0] RT_BGEZ    = 5'h01;

   localparam logic [1:0] PCSEL_SEQ  = 2'b00;
   localparam logic [1:0] PCSEL_TGT  = 2'b01;
   localparam logic [1:0] PCSEL_EXC  = 2'b10;
   localparam logic [1:0] PCSEL_REG  = 2'b11;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEM    = 2'b01;
   localparam logic [1:0] FWD_WB     = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_EXC   = 2'd2
   } state_e;

   typedef struct packed {
      logic is_br;
      logic use_rs;
      logic use_rt;
      logic jump;
      logic reg_tgt;
   } br_dec_t;

   function automatic br_dec_t decode_br(input logic [5:0] op,
                                         input logic [5:0] func,
                                         input logic [4:0] rt);
      br_dec_t d;
      d = '0;
      case (op)
         OP_BEQ, OP_BNE: begin
            d.is_br  = 1'b1;
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
         end
         OP_REGIMM: begin
            if (rt == RT_BGEZ) begin
               d.is_br  = 1'b1;
               d.use_rs = 1'b1;
            end
         end
         OP_J, OP_JAL: begin
            d.is_br = 1'b1;
            d.jump  = 1'b1;
         end
         OP_SPECIAL: begin
            case (func)
               FN_TEQ: begin
                  d.is_br  = 1'b1;
                  d.use_rs = 1'b1;
                  d.use_rt = 1'b1;
               end
               FN_JR, FN_JALR: begin
                  d.is_br   = 1'b1;
                  d.use_rs  = 1'b1;
                  d.jump    = 1'b1;
                  d.reg_tgt = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational stall-length and comparator operand forwarding selection for
// the two ID source registers.
module branch_hazard_detect
   import branch_ctrl_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rt_i,
   input  logic       use_rs_i,
   input  logic       use_rt_i,
   input  logic       ex_regwrite_i,
   input  logic       ex_memread_i,
   input  logic [4:0] ex_rd_i,
   input  logic       mem_regwrite_i,
   input  logic       mem_memread_i,
   input  logic [4:0] mem_rd_i,
   input  logic       wb_regwrite_i,
   input  logic [4:0] wb_rd_i,
   output logic [1:0] stall_n_o,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   logic [1:0] n_rs, n_rt;

   // An EX match always needs at least as long as a MEM load match, so it wins.
   function automatic logic [1:0] stall_len(input logic [4:0] src,
                                            input logic       ex_rw,
                                            input logic       ex_mr,
                                            input logic [4:0] ex_rd,
                                            input logic       mem_mr,
                                            input logic [4:0] mem_rd);
      logic [1:0] n;
      n = 2'd0;
      if (src != '0) begin
         if (ex_rw && (ex_rd == src))        n = ex_mr ? 2'd2 : 2'd1;
         else if (mem_mr && (mem_rd == src)) n = 2'd1;
      end
      return n;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       mem_rw,
                                          input logic       mem_mr,
                                          input logic [4:0] mem_rd,
                                          input logic       wb_rw,
                                          input logic [4:0] wb_rd);
      logic [1:0] f;
      f = FWD_RF;
      if (src != '0) begin
         if (mem_rw && !mem_mr && (mem_rd == src)) f = FWD_MEM;
         else if (wb_rw && (wb_rd == src))         f = FWD_WB;
      end
      return f;
   endfunction

   always_comb begin
      n_rs      = '0;
      n_rt      = '0;
      if (use_rs_i)
         n_rs = stall_len(rs_i, ex_regwrite_i, ex_memread_i, ex_rd_i, mem_memread_i, mem_rd_i);
      if (use_rt_i)
         n_rt = stall_len(rt_i, ex_regwrite_i, ex_memread_i, ex_rd_i, mem_memread_i, mem_rd_i);
      stall_n_o = (n_rs > n_rt) ? n_rs : n_rt;
      fwd_a_o   = fwd_sel(rs_i, mem_regwrite_i, mem_memread_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
      fwd_b_o   = fwd_sel(rt_i, mem_regwrite_i, mem_memread_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
   end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on comparator RAW hazards, drives PC
// select/flush from the taken flag and exceptions, counts resolved branches.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned DELAY_SLOT = 0,
   parameter int unsigned EXC_FLUSH  = 2,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_id_valid,
   input  logic [5:0]       in_id_op,
   input  logic [5:0]       in_id_func,
   input  logic [4:0]       in_id_rs,
   input  logic [4:0]       in_id_rt,
   input  logic             in_ex_regwrite,
   input  logic             in_ex_memread,
   input  logic [4:0]       in_ex_rd,
   input  logic             in_mem_regwrite,
   input  logic             in_mem_memread,
   input  logic [4:0]       in_mem_rd,
   input  logic             in_wb_regwrite,
   input  logic [4:0]       in_wb_rd,
   input  logic             in_branch,
   input  logic             in_exception,
   output logic             out_stall,
   output logic             out_flush,
   output logic [1:0]       out_pc_sel,
   output logic [1:0]       out_fwd_a,
   output logic [1:0]       out_fwd_b,
   output logic [CNT_W-1:0] out_br_cnt,
   output logic [CNT_W-1:0] out_taken_cnt
);

   localparam logic [2:0]       EXC_LOAD = 3'(EXC_FLUSH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   br_dec_t          dec;
   logic [1:0]       stall_n;
   logic [1:0]       fwd_a, fwd_b;
   logic             stall_c, flush_c;
   logic [1:0]       pc_sel_c;

   assign dec = decode_br(in_id_op, in_id_func, in_id_rt);

   branch_hazard_detect u_hazard (
      .rs_i           (in_id_rs),
      .rt_i           (in_id_rt),
      .use_rs_i       (dec.use_rs),
      .use_rt_i       (dec.use_rt),
      .ex_regwrite_i  (in_ex_regwrite),
      .ex_memread_i   (in_ex_memread),
      .ex_rd_i        (in_ex_rd),
      .mem_regwrite_i (in_mem_regwrite),
      .mem_memread_i  (in_mem_memread),
      .mem_rd_i       (in_mem_rd),
      .wb_regwrite_i  (in_wb_regwrite),
      .wb_rd_i        (in_wb_rd),
      .stall_n_o      (stall_n),
      .fwd_a_o        (fwd_a),
      .fwd_b_o        (fwd_b)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      stall_c     = 1'b0;
      flush_c     = 1'b0;
      pc_sel_c    = PCSEL_SEQ;
      case (state_q)
         // STALL shares the RUN arm so an exception aborts a stall identically.
         ST_RUN, ST_STALL: begin
            if (in_exception) begin
               pc_sel_c = PCSEL_EXC;
               flush_c  = 1'b1;
               cnt_d    = EXC_LOAD;
               state_d  = (EXC_LOAD != '0) ? ST_EXC : ST_RUN;
            end else if (state_q == ST_STALL) begin
               stall_c = 1'b1;
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) state_d = ST_RUN;
            end else if (in_id_valid && dec.is_br) begin
               if (stall_n != '0) begin
                  stall_c = 1'b1;
                  cnt_d   = {1'b0, stall_n} - 3'd1;
                  state_d = (stall_n > 2'd1) ? ST_STALL : ST_RUN;
               end else begin
                  if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_ONE;
                  if (in_branch || dec.jump) begin
                     if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_ONE;
                     pc_sel_c = dec.reg_tgt ? PCSEL_REG : PCSEL_TGT;
                     flush_c  = (DELAY_SLOT == 0);
                  end
               end
            end
         end
         ST_EXC: begin
            flush_c = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign out_stall     = in_rst & stall_c;
   assign out_flush     = in_rst & flush_c;
   assign out_pc_sel    = in_rst ? pc_sel_c : PCSEL_SEQ;
   assign out_fwd_a     = in_rst ? fwd_a : FWD_RF;
   assign out_fwd_b     = in_rst ? fwd_b : FWD_RF;
   assign out_br_cnt    = in_rst ? br_cnt_q : '0;
   assign out_taken_cnt = in_rst ? taken_cnt_q : '0;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: single-cycle vector table plus multi-cycle
// stall, exception, reset and saturation sequences.
module tb_branch_ctrl;

   localparam logic [5:0] SPEC = 6'h00, REGIMM = 6'h01, OJ = 6'h02, OJAL = 6'h03;
   localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05;
   localparam logic [5:0] F0 = 6'h00, FJR = 6'h08, FJALR = 6'h09, FADD = 6'h20, FTEQ = 6'h34;
   localparam int NV = 17;

   typedef struct packed {
      logic       v;
      logic [5:0] op, fn;
      logic [4:0] rs, rt;
      logic       exrw, exmr;
      logic [4:0] exrd;
      logic       memrw, memmr;
      logic [4:0] memrd;
      logic       wbrw;
      logic [4:0] wbrd;
      logic       br, exc;
      logic       e_stall, e_flush;
      logic [1:0] e_pc, e_fa, e_fb;
      logic       e_bc, e_tc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, br, exc;
   logic [5:0] op, fn;
   logic [4:0] rs, rt, ex_rd, mem_rd, wb_rd;

   logic        stall, flush, ds_stall, ds_flush;
   logic [1:0]  pc, fa, fb, ds_pc, ds_fa, ds_fb;
   logic [3:0]  bc, tc;
   logic [31:0] ds_bc, ds_tc;

   int   checks, errors, br_m, tk_m;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   branch_ctrl #(.DELAY_SLOT(0), .EXC_FLUSH(2), .CNT_W(4)) u_dut (
      .in_clk(clk), .in_rst(rst_n), .in_id_valid(id_valid), .in_id_op(op), .in_id_func(fn),
      .in_id_rs(rs), .in_id_rt(rt), .in_ex_regwrite(ex_rw), .in_ex_memread(ex_mr),
      .in_ex_rd(ex_rd), .in_mem_regwrite(mem_rw), .in_mem_memread(mem_mr), .in_mem_rd(mem_rd),
      .in_wb_regwrite(wb_rw), .in_wb_rd(wb_rd), .in_branch(br), .in_exception(exc),
      .out_stall(stall), .out_flush(flush), .out_pc_sel(pc), .out_fwd_a(fa), .out_fwd_b(fb),
      .out_br_cnt(bc), .out_taken_cnt(tc)
   );

   branch_ctrl #(.DELAY_SLOT(1), .EXC_FLUSH(3), .CNT_W(32)) u_ds (
      .in_clk(clk), .in_rst(rst_n), .in_id_valid(id_valid), .in_id_op(op), .in_id_func(fn),
      .in_id_rs(rs), .in_id_rt(rt), .in_ex_regwrite(ex_rw), .in_ex_memread(ex_mr),
      .in_ex_rd(ex_rd), .in_mem_regwrite(mem_rw), .in_mem_memread(mem_mr), .in_mem_rd(mem_rd),
      .in_wb_regwrite(wb_rw), .in_wb_rd(wb_rd), .in_branch(br), .in_exception(exc),
      .out_stall(ds_stall), .out_flush(ds_flush), .out_pc_sel(ds_pc), .out_fwd_a(ds_fa),
      .out_fwd_b(ds_fb), .out_br_cnt(ds_bc), .out_taken_cnt(ds_tc)
   );

   function automatic int sat15(input int x);
      return (x > 15) ? 15 : x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_st, input logic e_fl,
                          input logic [1:0] e_pc, input logic [1:0] e_fa, input logic [1:0] e_fb);
      chk({tag, " stall"}, stall, e_st);
      chk({tag, " flush"}, flush, e_fl);
      chk({tag, " pc_sel"}, pc, e_pc);
      chk({tag, " fwd_a"}, fa, e_fa);
      chk({tag, " fwd_b"}, fb, e_fb);
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, " br_cnt"}, bc, sat15(br_m));
      chk({tag, " taken_cnt"}, tc, sat15(tk_m));
   endtask

   task automatic set_idle();
      id_valid = 1'b0; op = F0; fn = F0; rs = '0; rt = '0;
      ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0;
      mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = '0;
      wb_rw = 1'b0; wb_rd = '0; br = 1'b0; exc = 1'b0;
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v; op = t.op; fn = t.fn; rs = t.rs; rt = t.rt;
      ex_rw = t.exrw; ex_mr = t.exmr; ex_rd = t.exrd;
      mem_rw = t.memrw; mem_mr = t.memmr; mem_rd = t.memrd;
      wb_rw = t.wbrw; wb_rd = t.wbrd; br = t.br; exc = t.exc;
   endtask

   task automatic reset_dut();
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      br_m = 0;
      tk_m = 0;
   endtask

   initial begin
      checks = 0; errors = 0; br_m = 0; tk_m = 0;
      //         v    op     fn     rs     rt     exrw exmr exrd   mrw  mmr  mrd    wrw  wrd    br   exc   st   fl   pc     fa     fb     bc   tc
      vecs[0]  = '{1'b0,BEQ,   F0,    5'd8,  5'd9,  1'b1,1'b1,5'd8,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b1,1'b0, 1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
      vecs[1]  = '{1'b1,BEQ,   F0,    5'd0,  5'd0,  1'b1,1'b0,5'd0,  1'b1,1'b0,5'd0,  1'b0,5'd0,  1'b1,1'b0, 1'b0,1'b1,2'b01,2'b00,2'b00,1'b1,1'b1};
      vecs[2]  = '{1'b1,SPEC,  FADD,  5'd3,  5'd4,  1'b1,1'b0,5'd3,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
      vecs[3]  = '{1'b1,BNE,   F0,    5'd3,  5'd0,  1'b1,1'b0,5'd3,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
      vecs[4]  = '{1'b1,BNE,   F0,    5'd3,  5'd0,  1'b0,1'b0,5'd0,  1'b1,1'b0,5'd3,  1'b0,5'd0,  1'b0,1'b0, 1'b0,1'b0,2'b00,2'b01,2'b00,1'b1,1'b0};
      vecs[5]  = '{1'b1,BEQ,   F0,    5'd8,  5'd9,  1'b0,1'b0,5'd0,  1'b1,1'b0,5'd9,  1'b1,5'd8,  1'b1,1'b0, 1'b0,1'b1,2'b01,2'b10,2'b01,1'b1,1'b1};
      vecs[6]  = '{1'b1,BEQ,   F0,    5'd5,  5'd5,  1'b0,1'b0,5'd0,  1'b1,1'b0,5'd5,  1'b1,5'd5,  1'b0,1'b0, 1'b0,1'b0,2'b00,2'b01,2'b01,1'b1,1'b0};
      vecs[7]  = '{1'b1,BEQ,   F0,    5'd5,  5'd6,  1'b0,1'b0,5'd0,  1'b1,1'b1,5'd5,  1'b1,5'd5,  1'b0,1'b0, 1'b1,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0};
      vecs[8]  = '{1'b1,REGIMM,F0,    5'd7,  5'd1,  1'b1,1'b1,5'd1,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b1,1'b0, 1'b0,1'b1,2'b01,2'b00,2'b00,1'b1,1'b1};
      vecs[9]  = '{1'b1,OJ,    F0,    5'd4,  5'd4,  1'b1,1'b1,5'd4,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b0,1'b1,2'b01,2'b00,2'b00,1'b1,1'b1};
      vecs[10] = '{1'b1,SPEC,  FJR,   5'd31, 5'd0,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b1,5'd31, 1'b0,1'b0, 1'b0,1'b1,2'b11,2'b10,2'b00,1'b1,1'b1};
      vecs[11] = '{1'b1,SPEC,  FJALR, 5'd31, 5'd0,  1'b1,1'b0,5'd31, 1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
      vecs[12] = '{1'b1,SPEC,  FTEQ,  5'd2,  5'd3,  1'b1,1'b1,5'd3,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
      vecs[13] = '{1'b1,BEQ,   F0,    5'd0,  5'd0,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b1,1'b1, 1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
      vecs[14] = '{1'b1,OJAL,  F0,    5'd0,  5'd0,  1'b0,1'b0,5'd0,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b0, 1'b0,1'b1,2'b01,2'b00,2'b00,1'b1,1'b1};
      vecs[15] = '{1'b1,BEQ,   F0,    5'd1,  5'd2,  1'b1,1'b0,5'd1,  1'b0,1'b0,5'd0,  1'b0,5'd0,  1'b0,1'b1, 1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
      vecs[16] = '{1'b1,BEQ,   F0,    5'd4,  5'd6,  1'b0,1'b0,5'd0,  1'b1,1'b1,5'd6,  1'b0,5'd0,  1'b0,1'b0, 1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};

      reset_dut();
      #1;
      chk_out("reset", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      chk_cnt("reset");

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk_out($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                 vecs[i].e_pc, vecs[i].e_fa, vecs[i].e_fb);
         chk($sformatf("v%0d ds_stall", i), ds_stall, vecs[i].e_stall);
         chk($sformatf("v%0d ds_pc_sel", i), ds_pc, vecs[i].e_pc);
         chk($sformatf("v%0d ds_flush", i), ds_flush, (vecs[i].e_pc == 2'b10));
         br_m += int'(vecs[i].e_bc);
         tk_m += int'(vecs[i].e_tc);
         @(posedge clk);
         #1;
         chk_cnt($sformatf("v%0d", i));
         set_idle();
         repeat (3) @(posedge clk);
      end

      // Load-use: two stall cycles, then WB forwarding and taken resolution
      reset_dut();
      @(negedge clk);
      set_idle(); id_valid = 1'b1; op = BEQ; rs = 5'd8; rt = 5'd9;
      ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd8;
      #1 chk_out("lu c1", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0; mem_rw = 1'b1; mem_mr = 1'b1; mem_rd = 5'd8;
      #1 chk_out("lu c2", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = '0; wb_rw = 1'b1; wb_rd = 5'd8; br = 1'b1;
      #1 chk_out("lu c3", 1'b0, 1'b1, 2'b01, 2'b10, 2'b00);
      chk("lu c3 ds_flush", ds_flush, 1'b0);
      br_m = 1; tk_m = 1;
      @(negedge clk);
      set_idle();
      #1 chk_cnt("lu");

      // ALU hazard: one stall, then MEM forwarding, not taken
      @(negedge clk);
      id_valid = 1'b1; op = BNE; rs = 5'd3; rt = 5'd0; ex_rw = 1'b1; ex_rd = 5'd3;
      #1 chk_out("alu c1", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      ex_rw = 1'b0; ex_rd = '0; mem_rw = 1'b1; mem_rd = 5'd3;
      #1 chk_out("alu c2", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
      br_m = 2;
      @(negedge clk);
      set_idle();
      #1 chk_cnt("alu");

      // Exception in the first STALL cycle; EXC ignores branches
      @(negedge clk);
      id_valid = 1'b1; op = BEQ; rs = 5'd8; rt = 5'd9; ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd8;
      #1 chk_out("xs c1", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      exc = 1'b1;
      #1 chk_out("xs c2", 1'b0, 1'b1, 2'b10, 2'b00, 2'b00);
      @(negedge clk);
      set_idle(); id_valid = 1'b1; op = BEQ; br = 1'b1;
      #1 chk_out("xs c3", 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      #1 chk_out("xs c4", 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
      chk("xs c4 ds_flush", ds_flush, 1'b1);
      chk("xs c4 ds_pc_sel", ds_pc, 2'b00);
      br_m = 3; tk_m = 2;
      @(negedge clk);
      set_idle();
      #1 chk_cnt("xs");
      chk("xs c5 ds_flush", ds_flush, 1'b0);

      // Reset asserted mid-EXC; outputs idle and counters cleared
      @(negedge clk);
      exc = 1'b1;
      #1 chk_out("rx c1", 1'b0, 1'b1, 2'b10, 2'b00, 2'b00);
      @(negedge clk);
      exc = 1'b0; rst_n = 1'b0; id_valid = 1'b1; op = BEQ; rs = 5'd8; rt = 5'd9;
      mem_rw = 1'b1; mem_rd = 5'd8; wb_rw = 1'b1; wb_rd = 5'd9; ex_rw = 1'b1; ex_rd = 5'd9;
      #1 chk_out("rx c2", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      br_m = 0; tk_m = 0;
      #1 chk_cnt("rx");
      @(negedge clk);
      rst_n = 1'b1; set_idle(); id_valid = 1'b1; op = BEQ; br = 1'b1;
      #1 chk_out("rx c4", 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
      chk("rx c4 ds_pc_sel", ds_pc, 2'b01);

      // Saturation: 20 taken branches on the 4-bit instance
      repeat (20) @(posedge clk);
      #1 set_idle();
      br_m = 20; tk_m = 20;
      #1 chk_cnt("sat");
      chk("sat ds_br_cnt", ds_bc, 32'd20);
      chk("sat ds_taken_cnt", ds_tc, 32'd20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
